// File: rtl/arith_loop_pkg.sv
// Shared constants, state encoding and helpers for the
// arithmetic loop counter and its rewind companion.
package arith_loop_pkg;

  localparam int W  = 23;
  localparam int XW = W + 2;

  localparam logic [W-1:0] I_INIT  = W'(1);
  localparam logic [W-1:0] J_INIT  = W'(1000);
  localparam logic [W-1:0] J_FLOOR = W'(666);
  localparam logic [W-1:0] I_STEP  = W'(2);
  localparam logic [W-1:0] J_STEP  = W'(1);

  localparam logic [XW-1:0] SUM_INV =
    XW'(I_INIT) + XW'(I_STEP) * XW'(J_INIT);
  localparam logic [XW-1:0] I_MAX =
    XW'(I_INIT) +
    XW'(I_STEP) * (XW'(J_INIT) - XW'(J_FLOOR));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REWIND,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic [XW-1:0] widen(
    input logic [W-1:0] v
  );
    return {2'b00, v};
  endfunction

endpackage

// File: rtl/arith_loop_rewind_if.sv
// Snapshot load / status bundle of the rewind block.
// master drives the snapshot, slave is the rewind block.
interface arith_loop_rewind_if;
  import arith_loop_pkg::*;

  logic         load;
  logic [W-1:0] load_i;
  logic [W-1:0] load_j;
  logic         selector;
  logic [W-1:0] i;
  logic [W-1:0] j;
  logic [W-1:0] steps;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output load, load_i, load_j, selector,
    input  i, j, steps, busy, done, err
  );

  modport slave (
    input  load, load_i, load_j, selector,
    output i, j, steps, busy, done, err
  );

endinterface

// File: rtl/arith_loop_reach_check.sv
// Reachability predicate for a loop snapshot (i, j).
// Evaluated two bits wider so no term can wrap.
module arith_loop_reach_check
  import arith_loop_pkg::*;
(
  input  logic [W-1:0] cap_i_i,
  input  logic [W-1:0] cap_j_i,
  output logic         valid_o
);

  logic [XW-1:0] ci;
  logic [XW-1:0] cj;
  logic [XW-1:0] sum;
  logic          j_ok;
  logic          s_ok;
  logic          i_ok;

  assign ci  = widen(cap_i_i);
  assign cj  = widen(cap_j_i);
  assign sum = ci + widen(I_STEP) * cj;

  assign j_ok = (cj >= widen(J_FLOOR)) &&
                (cj <= widen(J_INIT));
  assign s_ok = (sum == SUM_INV);
  assign i_ok = (ci <= I_MAX);

  assign valid_o = j_ok && s_ok && i_ok;

endmodule

// File: rtl/arith_loop_rewind.sv
// Unwinds a reachable (i, j) snapshot of the forward
// loop back to its origin, one step per enabled cycle.
module arith_loop_rewind
  import arith_loop_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  arith_loop_rewind_if.slave  bus
);

  state_e       state_q;
  logic [W-1:0] i_q;
  logic [W-1:0] j_q;
  logic [W-1:0] steps_q;
  logic [W-1:0] cap_i_q;
  logic [W-1:0] cap_j_q;
  logic         busy_q;
  logic         done_q;
  logic         err_q;

  logic [W-1:0] i_d;
  logic [W-1:0] j_d;
  logic [W-1:0] steps_d;
  logic         reach_ok;
  logic         idle_like;

  arith_loop_reach_check u_reach (
    .cap_i_i (cap_i_q),
    .cap_j_i (cap_j_q),
    .valid_o (reach_ok)
  );

  // One rewind step applied to the current datapath.
  always_comb begin
    i_d     = i_q - I_STEP;
    j_d     = j_q + J_STEP;
    steps_d = steps_q + W'(1);
  end

  assign idle_like = (state_q == S_IDLE) ||
                     (state_q == S_DONE) ||
                     (state_q == S_ERR);

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= I_INIT;
      j_q     <= J_INIT;
      steps_q <= '0;
      cap_i_q <= '0;
      cap_j_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        idle_like: begin
          if (bus.load) begin
            cap_i_q <= bus.load_i;
            cap_j_q <= bus.load_j;
            state_q <= S_CHECK;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        (state_q == S_CHECK): begin
          if (reach_ok) begin
            i_q     <= cap_i_q;
            j_q     <= cap_j_q;
            steps_q <= '0;
            if (cap_j_q == J_INIT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_REWIND;
            end
          end else begin
            state_q <= S_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        (state_q == S_REWIND): begin
          if (bus.selector) begin
            i_q     <= i_d;
            j_q     <= j_d;
            steps_q <= steps_d;
            if (j_d == J_INIT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i     = i_q;
  assign bus.j     = j_q;
  assign bus.steps = steps_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule
